// File: rtl/commit_rat_pkg.sv
// Shared types for the architectural RAT commit block: index types,
// commit/squash bundles, restore FSM states and the restore beat count.
package commit_rat_pkg;

  localparam int COMMIT_WIDTH  = 4;
  localparam int NUM_ILR       = 32;
  localparam int RESTORE_WIDTH = 8;
  localparam int NUM_IPR       = 128;

  localparam int ILR_W = $clog2(NUM_ILR);
  localparam int IPR_W = $clog2(NUM_IPR);

  localparam int RESTORE_BEATS = NUM_ILR / RESTORE_WIDTH;
  localparam int BEAT_W =
    (RESTORE_BEATS > 1) ? $clog2(RESTORE_BEATS) : 1;

  typedef logic [ILR_W-1:0] ilrIdx_t;
  typedef logic [IPR_W-1:0] iprIdx_t;

  typedef struct packed {
    logic    ismv;
    logic    has_rd;
    ilrIdx_t ilrd_idx;
    iprIdx_t iprd_idx;
    iprIdx_t prev_iprd_idx;
  } renameCommitInfo_t;

  typedef struct packed {
    logic [5:0] rob_idx;
    logic       mispred;
  } squashInfo_t;

  typedef enum logic {
    IDLE,
    RESTORE
  } rat_state_e;

endpackage

// File: rtl/commit_rat_wsel.sv
// Per-ilr last-writer select across commit lanes (combinational).
// Ports: lane_en/lane_ilr/lane_ipr in; wr_en/wr_ipr per ilr out.
module commit_rat_wsel
  import commit_rat_pkg::*;
(
  input  logic    [COMMIT_WIDTH-1:0] lane_en,
  input  ilrIdx_t [COMMIT_WIDTH-1:0] lane_ilr,
  input  iprIdx_t [COMMIT_WIDTH-1:0] lane_ipr,
  output logic    [NUM_ILR-1:0]      wr_en,
  output iprIdx_t [NUM_ILR-1:0]      wr_ipr
);

  // Ascending lane order: the youngest (highest) lane wins.
  always_comb begin
    wr_en  = '0;
    wr_ipr = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (lane_en[k]) begin
        wr_en[lane_ilr[k]]  = 1'b1;
        wr_ipr[lane_ilr[k]] = lane_ipr[k];
      end
    end
  end

endmodule

// File: rtl/commit_rat.sv
// Architectural int RAT: applies commits, releases superseded pregs,
// and replays the RAT to the speculative RAT after a squash.
// Ports: commit stream in / rdy out, squash in, free lanes out,
// restore beats out. Option COMMIT_RAT_DIFFTEST_EN adds o_arch_rat.
module commit_rat
  import commit_rat_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic    [COMMIT_WIDTH-1:0]     i_commit_vld,
  input  renameCommitInfo_t [COMMIT_WIDTH-1:0] i_commit_info,
  output logic                           o_commit_rdy,
  input  logic                           i_squash_vld,
  input  squashInfo_t                    i_squash_info,
  output logic    [COMMIT_WIDTH-1:0]     o_free_vld,
  output iprIdx_t [COMMIT_WIDTH-1:0]     o_free_iprIdx,
  output logic    [COMMIT_WIDTH-1:0]     o_free_ismv,
  output logic                           o_restore_busy,
  output logic                           o_restore_vld,
  output ilrIdx_t [RESTORE_WIDTH-1:0]    o_restore_ilrIdx,
  output iprIdx_t [RESTORE_WIDTH-1:0]    o_restore_iprIdx
`ifdef COMMIT_RAT_DIFFTEST_EN
  ,
  output iprIdx_t [NUM_ILR-1:0]          o_arch_rat
`endif
);

  rat_state_e          state_q, state_d;
  logic   [BEAT_W-1:0] beat_q, beat_d;
  iprIdx_t [NUM_ILR-1:0] rat_q;

  logic    [COMMIT_WIDTH-1:0] eff;
  ilrIdx_t [COMMIT_WIDTH-1:0] lane_ilr;
  iprIdx_t [COMMIT_WIDTH-1:0] lane_ipr;
  logic    [NUM_ILR-1:0]      wr_en;
  iprIdx_t [NUM_ILR-1:0]      wr_ipr;

  // Squash info only matters for trace.
  logic unused_squash_info;
  assign unused_squash_info = ^i_squash_info;

  assign o_commit_rdy = (state_q == IDLE);

  always_comb begin
    eff      = '0;
    lane_ilr = '0;
    lane_ipr = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      lane_ilr[k] = i_commit_info[k].ilrd_idx;
      lane_ipr[k] = i_commit_info[k].iprd_idx;
      eff[k] = i_commit_vld[k] && o_commit_rdy
            && i_commit_info[k].has_rd
            && (i_commit_info[k].ilrd_idx != '0);
    end
  end

  commit_rat_wsel u_wsel (
    .lane_en  (eff),
    .lane_ilr (lane_ilr),
    .lane_ipr (lane_ipr),
    .wr_en    (wr_en),
    .wr_ipr   (wr_ipr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ILR; i++)
        rat_q[i] <= iprIdx_t'(i);
    end else begin
      for (int i = 0; i < NUM_ILR; i++)
        if (wr_en[i]) rat_q[i] <= wr_ipr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_free_vld    <= '0;
      o_free_iprIdx <= '0;
      o_free_ismv   <= '0;
    end else begin
      o_free_vld <= eff;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        o_free_iprIdx[k] <= eff[k] ?
          i_commit_info[k].prev_iprd_idx : '0;
        o_free_ismv[k] <= eff[k] && i_commit_info[k].ismv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (i_squash_vld) state_d = RESTORE;
      end
      RESTORE: begin
        if (i_squash_vld) begin
          beat_d = '0;
        end else if (beat_q ==
                     BEAT_W'(RESTORE_BEATS - 1)) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    ilrIdx_t ridx;
    ridx             = '0;
    o_restore_vld    = (state_q == RESTORE);
    o_restore_busy   = (state_q == RESTORE);
    o_restore_ilrIdx = '0;
    o_restore_iprIdx = '0;
    if (state_q == RESTORE) begin
      for (int j = 0; j < RESTORE_WIDTH; j++) begin
        ridx = ilrIdx_t'(int'(beat_q) * RESTORE_WIDTH + j);
        o_restore_ilrIdx[j] = ridx;
        o_restore_iprIdx[j] = rat_q[ridx];
      end
    end
  end

`ifdef COMMIT_RAT_DIFFTEST_EN
  assign o_arch_rat = rat_q;
`endif

endmodule

// File: tb/tb_commit_rat.sv
// Directed bench for commit_rat: commits, releases, squash
// restore walks, restart on squash, reset mid-restore.
module tb_commit_rat;
  import commit_rat_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [COMMIT_WIDTH-1:0] commit_vld;
  renameCommitInfo_t [COMMIT_WIDTH-1:0] commit_info;
  logic commit_rdy;
  logic squash_vld;
  squashInfo_t squash_info;
  logic [COMMIT_WIDTH-1:0] free_vld;
  iprIdx_t [COMMIT_WIDTH-1:0] free_ipr;
  logic [COMMIT_WIDTH-1:0] free_ismv;
  logic restore_busy, restore_vld;
  ilrIdx_t [RESTORE_WIDTH-1:0] restore_ilr;
  iprIdx_t [RESTORE_WIDTH-1:0] restore_ipr;
`ifdef COMMIT_RAT_DIFFTEST_EN
  iprIdx_t [NUM_ILR-1:0] arch_rat;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model [NUM_ILR];

  always #5 clk = ~clk;

  commit_rat dut (
    .clk              (clk),
    .rst              (rst),
    .i_commit_vld     (commit_vld),
    .i_commit_info    (commit_info),
    .o_commit_rdy     (commit_rdy),
    .i_squash_vld     (squash_vld),
    .i_squash_info    (squash_info),
    .o_free_vld       (free_vld),
    .o_free_iprIdx    (free_ipr),
    .o_free_ismv      (free_ismv),
    .o_restore_busy   (restore_busy),
    .o_restore_vld    (restore_vld),
    .o_restore_ilrIdx (restore_ilr),
    .o_restore_iprIdx (restore_ipr)
`ifdef COMMIT_RAT_DIFFTEST_EN
    ,
    .o_arch_rat       (arch_rat)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic renameCommitInfo_t mk(
    input logic ismv, input logic has_rd,
    input int ilr, input int ipr, input int prev);
    renameCommitInfo_t c;
    c.ismv          = ismv;
    c.has_rd        = has_rd;
    c.ilrd_idx      = ilrIdx_t'(ilr);
    c.iprd_idx      = iprIdx_t'(ipr);
    c.prev_iprd_idx = iprIdx_t'(prev);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    commit_vld  = '0;
    commit_info = '0;
    squash_vld  = 1'b0;
  endtask

  task automatic chk_beat(input int b);
    chk($sformatf("vld_b%0d", b), 32'(restore_vld), 1);
    chk($sformatf("busy_b%0d", b), 32'(restore_busy), 1);
    chk($sformatf("rdy_b%0d", b), 32'(commit_rdy), 0);
    for (int j = 0; j < RESTORE_WIDTH; j++) begin
      chk($sformatf("ilr_b%0d_%0d", b, j),
          32'(restore_ilr[j]), b * RESTORE_WIDTH + j);
      chk($sformatf("ipr_b%0d_%0d", b, j),
          32'(restore_ipr[j]), model[b * RESTORE_WIDTH + j]);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, 32'(restore_vld), 0);
    chk({tag, "_busy"}, 32'(restore_busy), 0);
    chk({tag, "_rdy"}, 32'(commit_rdy), 1);
  endtask

  initial begin
    for (int i = 0; i < NUM_ILR; i++) model[i] = i;
    squash_info = '0;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_free", 32'(free_vld), 0);
    chk_idle("rst");
`ifdef COMMIT_RAT_DIFFTEST_EN
    chk("rst_rat5", 32'(arch_rat[5]), 5);
`endif

    commit_vld     = 4'b0001;
    commit_info[0] = mk(0, 1, 3, 40, 3);
    tick();
    idle_in();
    model[3] = 40;
    chk("c1_fvld", 32'(free_vld), 32'b0001);
    chk("c1_fipr0", 32'(free_ipr[0]), 3);
    chk("c1_ismv", 32'(free_ismv), 0);
    tick();
    chk("c1_fvld_off", 32'(free_vld), 0);

    commit_vld     = 4'b0111;
    commit_info[0] = mk(0, 1, 7, 41, 7);
    commit_info[1] = mk(0, 0, 0, 0, 0);
    commit_info[2] = mk(0, 1, 7, 42, 41);
    tick();
    idle_in();
    model[7] = 42;
    chk("c2_fvld", 32'(free_vld), 32'b0101);
    chk("c2_fipr0", 32'(free_ipr[0]), 7);
    chk("c2_fipr2", 32'(free_ipr[2]), 41);

    commit_vld     = 4'b0111;
    commit_info[0] = mk(0, 1, 0, 51, 50);
    commit_info[1] = mk(0, 0, 6, 52, 50);
    commit_info[2] = mk(1, 1, 4, 60, 9);
    tick();
    idle_in();
    model[4] = 60;
    chk("c3_fvld", 32'(free_vld), 32'b0100);
    chk("c3_fipr2", 32'(free_ipr[2]), 9);
    chk("c3_ismv", 32'(free_ismv), 32'b0100);

    squash_vld     = 1'b1;
    commit_vld     = 4'b0001;
    commit_info[0] = mk(0, 1, 1, 45, 1);
    tick();
    idle_in();
    model[1] = 45;
    chk("sq_fvld", 32'(free_vld), 32'b0001);
    chk("sq_fipr0", 32'(free_ipr[0]), 1);
    chk_beat(0);
    commit_vld     = 4'b0001;
    commit_info[0] = mk(0, 1, 10, 70, 10);
    tick();
    idle_in();
    chk("blk_fvld", 32'(free_vld), 0);
    chk_beat(1);
    tick();
    chk_beat(2);
    tick();
    chk_beat(3);
    tick();
    chk_idle("sq_done");

    squash_vld = 1'b1;
    tick();
    idle_in();
    chk_beat(0);
    tick();
    chk_beat(1);
    tick();
    chk_beat(2);
    squash_vld = 1'b1;
    tick();
    idle_in();
    for (int b = 0; b < RESTORE_BEATS; b++) begin
      chk_beat(b);
      tick();
    end
    chk_idle("rs_done");

    commit_vld     = 4'b0001;
    commit_info[0] = mk(0, 1, 5, 80, 5);
    squash_vld     = 1'b1;
    tick();
    idle_in();
    model[5] = 80;
    chk_beat(0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NUM_ILR; i++) model[i] = i;
    chk("mr_vld", 32'(restore_vld), 0);
    chk("mr_busy", 32'(restore_busy), 0);
    chk("mr_fvld", 32'(free_vld), 0);
    rst = 1'b0;
    squash_vld = 1'b1;
    tick();
    idle_in();
    for (int b = 0; b < RESTORE_BEATS; b++) begin
      chk_beat(b);
      tick();
    end
    chk_idle("mr_done");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
